// File: rtl/ibias_bg_seq.sv
// Bandgap/bias power-up sequencer: startup kick, settle wait, channel-by-channel ramp, fault filter.
// Latency: every output is registered, so outputs reflect the state decided on the previous rising edge.
// Backpressure: none; requests are level inputs sampled on every edge, and EN_I=0 always wins.
module ibias_bg_seq #(
    parameter int N_CH        = 16,
    parameter int TI_W        = 5,
    parameter int TV_W        = 4,
    parameter int STARTUP_CYC = 32,
    parameter int SETTLE_CYC  = 128,
    parameter int RAMP_CYC    = 4,
    parameter int FILT_CYC    = 3
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            EN_I,
    input  logic            EN_VBIAS_I,
    input  logic [N_CH-1:0] CH_EN_I,
    input  logic [TI_W-1:0] TRIM_IBIAS_I,
    input  logic [TV_W-1:0] TRIM_VBIAS_I,
    input  logic            TRIM_LOAD_I,
    input  logic            BG_VALID_I,
    output logic            EN_IBIAS_O,
    output logic            EN_VBIAS_O,
    output logic            BG_STARTUP_O,
    output logic [TI_W-1:0] TRIM_IBIAS_O,
    output logic [TV_W-1:0] TRIM_VBIAS_O,
    output logic [N_CH-1:0] CH_EN_O,
    output logic            READY_O,
    output logic            FAULT_O,
    output logic [2:0]      STATE_O
);

    localparam int MAX_SR  = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_SR > RAMP_CYC) ? MAX_SR : RAMP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int FLT_W   = $clog2(FILT_CYC) + 1;

    localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_LD    = CNT_W'(RAMP_CYC - 1);
    localparam logic [FLT_W-1:0] FILT_LIM   = FLT_W'(FILT_CYC);
    localparam logic [N_CH-1:0]  CH_ONE     = N_CH'(1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STARTUP = 3'd1,
        S_SETTLE  = 3'd2,
        S_RAMP    = 3'd3,
        S_READY   = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [FLT_W-1:0]  r_filt, w_filt_nxt, w_filt_cnt;
    logic              w_filt_hit;
    logic [N_CH-1:0]   r_ch, w_ch_nxt, w_pend, w_pick, w_ch_kept;
    logic [TI_W-1:0]   r_ti, w_ti_nxt;
    logic [TV_W-1:0]   r_tv, w_tv_nxt;
    logic              r_en_ibias, r_en_vbias, r_bg_startup, r_ready, r_fault;
    logic              w_active_nxt;

    // Channel bookkeeping and bandgap-valid glitch filter terms.
    always_comb begin
        w_pend     = CH_EN_I & ~r_ch;
        w_pick     = w_pend & (~w_pend + CH_ONE);   // isolate lowest pending channel
        w_ch_kept  = r_ch & CH_EN_I;                // dropped requests release immediately
        w_filt_cnt = BG_VALID_I ? '0 : (r_filt + FLT_W'(1));
        w_filt_hit = !BG_VALID_I && ((r_filt + FLT_W'(1)) == FILT_LIM);
    end

    // Next-state decision: disable, then fault, then trim reload, then timer progress.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_filt_nxt  = '0;
        w_ch_nxt    = r_ch;
        w_ti_nxt    = r_ti;
        w_tv_nxt    = r_tv;
        if (!EN_I) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
            w_ch_nxt    = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_STARTUP;
                    w_cnt_nxt   = STARTUP_LD;
                    w_ti_nxt    = TRIM_IBIAS_I;
                    w_tv_nxt    = TRIM_VBIAS_I;
                end
                S_STARTUP: begin
                    if (TRIM_LOAD_I) begin
                        w_ti_nxt = TRIM_IBIAS_I;
                        w_tv_nxt = TRIM_VBIAS_I;
                    end
                    if (r_cnt == '0) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = SETTLE_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (TRIM_LOAD_I) begin
                        w_ti_nxt = TRIM_IBIAS_I;
                        w_tv_nxt = TRIM_VBIAS_I;
                    end
                    if (r_cnt == '0) begin
                        if (BG_VALID_I) begin
                            w_state_nxt = S_RAMP;
                            w_cnt_nxt   = RAMP_LD;
                        end else begin
                            w_state_nxt = S_FAULT;
                            w_ch_nxt    = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_RAMP, S_READY: begin
                    w_filt_nxt = w_filt_cnt;
                    if (w_filt_hit) begin
                        w_state_nxt = S_FAULT;
                        w_ch_nxt    = '0;
                        w_cnt_nxt   = '0;
                        w_filt_nxt  = '0;
                    end else if (TRIM_LOAD_I) begin
                        // Re-settle after a trim change; channels stay as they are.
                        w_ti_nxt    = TRIM_IBIAS_I;
                        w_tv_nxt    = TRIM_VBIAS_I;
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = SETTLE_LD;
                        w_filt_nxt  = '0;
                    end else if (r_state == S_RAMP) begin
                        w_ch_nxt = w_ch_kept;
                        if (r_cnt == '0) begin
                            w_ch_nxt  = w_ch_kept | w_pick;
                            w_cnt_nxt = RAMP_LD;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                        if ((CH_EN_I & ~w_ch_nxt) == '0) begin
                            w_state_nxt = S_READY;
                        end
                    end else begin
                        w_ch_nxt = w_ch_kept;
                        if (w_pend != '0) begin
                            w_state_nxt = S_RAMP;
                            w_cnt_nxt   = RAMP_LD;
                        end
                    end
                end
                S_FAULT: begin
                    w_ch_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                    w_ch_nxt    = '0;
                end
            endcase
        end
        w_active_nxt = (w_state_nxt == S_STARTUP) || (w_state_nxt == S_SETTLE) ||
                       (w_state_nxt == S_RAMP)    || (w_state_nxt == S_READY);
    end

    // State, timers, channel mask and trims; outputs are decoded from the next state.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_filt       <= '0;
            r_ch         <= '0;
            r_ti         <= '0;
            r_tv         <= '0;
            r_en_ibias   <= 1'b0;
            r_en_vbias   <= 1'b0;
            r_bg_startup <= 1'b0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_filt       <= w_filt_nxt;
            r_ch         <= w_ch_nxt;
            r_ti         <= w_ti_nxt;
            r_tv         <= w_tv_nxt;
            r_en_ibias   <= w_active_nxt;
            r_en_vbias   <= w_active_nxt && EN_VBIAS_I;
            r_bg_startup <= (w_state_nxt == S_STARTUP);
            r_ready      <= (w_state_nxt == S_READY);
            r_fault      <= (w_state_nxt == S_FAULT);
        end
    end

    assign EN_IBIAS_O   = r_en_ibias;
    assign EN_VBIAS_O   = r_en_vbias;
    assign BG_STARTUP_O = r_bg_startup;
    assign TRIM_IBIAS_O = r_ti;
    assign TRIM_VBIAS_O = r_tv;
    assign CH_EN_O      = r_ch;
    assign READY_O      = r_ready;
    assign FAULT_O      = r_fault;
    assign STATE_O      = r_state;

endmodule

// File: tb/tb_ibias_bg_seq.sv
// Testbench for ibias_bg_seq: directed power-up/fault/trim/mask/reset scenarios, then random traffic.
// Expected outputs come from a behavioural model, queued per edge and checked by a separate monitor.
// Outputs are sampled 1 time unit after each rising edge; inputs change 2 units after it.
module tb_ibias_bg_seq;

    localparam int N_CH        = 16;
    localparam int STARTUP_CYC = 32;
    localparam int SETTLE_CYC  = 128;
    localparam int RAMP_CYC    = 4;
    localparam int FILT_CYC    = 3;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        EN_I, EN_VBIAS_I, TRIM_LOAD_I, BG_VALID_I;
    logic [15:0] CH_EN_I;
    logic [4:0]  TRIM_IBIAS_I;
    logic [3:0]  TRIM_VBIAS_I;
    logic        EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, READY_O, FAULT_O;
    logic [4:0]  TRIM_IBIAS_O;
    logic [3:0]  TRIM_VBIAS_O;
    logic [15:0] CH_EN_O;
    logic [2:0]  STATE_O;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];

    // Behavioural model state
    int          m_state, m_cnt, m_filt;
    logic [15:0] m_ch;
    logic [4:0]  m_ti;
    logic [3:0]  m_tv;
    logic        m_vb;

    ibias_bg_seq #(
        .N_CH(N_CH), .TI_W(5), .TV_W(4), .STARTUP_CYC(STARTUP_CYC),
        .SETTLE_CYC(SETTLE_CYC), .RAMP_CYC(RAMP_CYC), .FILT_CYC(FILT_CYC)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .EN_VBIAS_I(EN_VBIAS_I),
        .CH_EN_I(CH_EN_I), .TRIM_IBIAS_I(TRIM_IBIAS_I), .TRIM_VBIAS_I(TRIM_VBIAS_I),
        .TRIM_LOAD_I(TRIM_LOAD_I), .BG_VALID_I(BG_VALID_I),
        .EN_IBIAS_O(EN_IBIAS_O), .EN_VBIAS_O(EN_VBIAS_O), .BG_STARTUP_O(BG_STARTUP_O),
        .TRIM_IBIAS_O(TRIM_IBIAS_O), .TRIM_VBIAS_O(TRIM_VBIAS_O), .CH_EN_O(CH_EN_O),
        .READY_O(READY_O), .FAULT_O(FAULT_O), .STATE_O(STATE_O)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic logic [32:0] dut_out();
        return {EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, TRIM_IBIAS_O, TRIM_VBIAS_O,
                CH_EN_O, READY_O, FAULT_O, STATE_O};
    endfunction

    function automatic logic [32:0] model_out();
        logic on;
        on = (m_state >= 1) && (m_state <= 4);
        return {on, m_vb, (m_state == 1), m_ti, m_tv, m_ch,
                (m_state == 4), (m_state == 5), 3'(m_state)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_filt = 0;
        m_ch = '0; m_ti = '0; m_tv = '0; m_vb = 1'b0;
    endtask

    // One clock edge of the sequencer, from the written rules.
    task automatic model_step();
        logic [15:0] pend, keep;
        if (!EN_I) begin
            m_state = 0; m_cnt = 0; m_filt = 0; m_ch = '0;
        end else begin
            case (m_state)
                0: begin
                    m_ti = TRIM_IBIAS_I; m_tv = TRIM_VBIAS_I;
                    m_state = 1; m_cnt = STARTUP_CYC - 1;
                end
                1: begin
                    if (TRIM_LOAD_I) begin m_ti = TRIM_IBIAS_I; m_tv = TRIM_VBIAS_I; end
                    if (m_cnt == 0) begin m_state = 2; m_cnt = SETTLE_CYC - 1; end
                    else m_cnt--;
                end
                2: begin
                    if (TRIM_LOAD_I) begin m_ti = TRIM_IBIAS_I; m_tv = TRIM_VBIAS_I; end
                    if (m_cnt == 0) begin
                        if (BG_VALID_I) begin m_state = 3; m_cnt = RAMP_CYC - 1; end
                        else begin m_state = 5; m_ch = '0; end
                    end else m_cnt--;
                end
                3, 4: begin
                    m_filt = BG_VALID_I ? 0 : m_filt + 1;
                    pend = CH_EN_I & ~m_ch;
                    keep = m_ch & CH_EN_I;
                    if (m_filt >= FILT_CYC) begin
                        m_state = 5; m_ch = '0; m_filt = 0;
                    end else if (TRIM_LOAD_I) begin
                        m_ti = TRIM_IBIAS_I; m_tv = TRIM_VBIAS_I;
                        m_state = 2; m_cnt = SETTLE_CYC - 1; m_filt = 0;
                    end else if (m_state == 3) begin
                        m_ch = keep;
                        if (m_cnt == 0) begin
                            for (int i = 0; i < 16; i++) begin
                                if (pend[i]) begin m_ch[i] = 1'b1; break; end
                            end
                            m_cnt = RAMP_CYC - 1;
                        end else m_cnt--;
                        if ((CH_EN_I & ~m_ch) == 16'h0) m_state = 4;
                    end else begin
                        m_ch = keep;
                        if (pend != 16'h0) begin m_state = 3; m_cnt = RAMP_CYC - 1; end
                    end
                end
                default: ;
            endcase
        end
        m_vb = EN_VBIAS_I && (m_state >= 1) && (m_state <= 4);
    endtask

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge: predict its outcome into the scoreboard, then let the edge happen.
    task automatic cyc();
        if (!RST_I) begin
            model_step();
            exp_q.push_back(model_out());
        end
        @(posedge CLK_I);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Monitor: every out-of-reset edge yields one output word to compare.
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge CLK_I);
            #1;
            if (!RST_I) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow at %0t got %h", $time, dut_out());
                end else begin
                    e = exp_q.pop_front();
                    if (dut_out() !== e) begin
                        errors++;
                        $display("FAIL cycle_outputs at %0t: got %h, expected %h", $time, dut_out(), e);
                    end
                end
            end
        end
    end

    initial begin
        RST_I = 1'b1; EN_I = 1'b0; EN_VBIAS_I = 1'b0; TRIM_LOAD_I = 1'b0; BG_VALID_I = 1'b1;
        CH_EN_I = 16'h0; TRIM_IBIAS_I = 5'h0; TRIM_VBIAS_I = 4'h0;
        model_reset();
        repeat (3) @(posedge CLK_I);
        #2;
        chk("reset_outputs", dut_out(), 33'h0);
        RST_I = 1'b0;

        // Normal power-up
        CH_EN_I = 16'h0003; TRIM_IBIAS_I = 5'h05; TRIM_VBIAS_I = 4'h9; EN_VBIAS_I = 1'b1;
        EN_I = 1'b1;
        cyc();                                   // edge k
        chk("pu_startup_state", 33'(STATE_O), 33'd1);
        chk("pu_startup_kick", 33'(BG_STARTUP_O), 33'd1);
        chk("pu_trim_latched", 33'({TRIM_IBIAS_O, TRIM_VBIAS_O}), 33'h59);
        run(31);                                 // k+31
        chk("pu_kick_last", 33'(BG_STARTUP_O), 33'd1);
        cyc();                                   // k+32
        chk("pu_settle_state", 33'(STATE_O), 33'd2);
        chk("pu_kick_off", 33'(BG_STARTUP_O), 33'd0);
        run(127);                                // k+159
        chk("pu_settle_last", 33'(STATE_O), 33'd2);
        cyc();                                   // k+160
        chk("pu_ramp_state", 33'(STATE_O), 33'd3);
        run(3);                                  // k+163
        chk("pu_ramp_none", 33'(CH_EN_O), 33'h0);
        cyc();                                   // k+164
        chk("pu_ch0", 33'(CH_EN_O), 33'h0001);
        run(3);
        cyc();                                   // k+168
        chk("pu_ch01", 33'(CH_EN_O), 33'h0003);
        chk("pu_ready", 33'(READY_O), 33'd1);

        // Trim reload from READY
        TRIM_IBIAS_I = 5'h1A; TRIM_LOAD_I = 1'b1;
        cyc();
        TRIM_LOAD_I = 1'b0;
        chk("tr_trim", 33'(TRIM_IBIAS_O), 33'h1A);
        chk("tr_settle", 33'(STATE_O), 33'd2);
        chk("tr_ch_held", 33'(CH_EN_O), 33'h0003);
        run(127);
        chk("tr_settle_end", 33'({STATE_O, CH_EN_O}), 33'h20003);
        run(2);
        chk("tr_ready_again", 33'({READY_O, STATE_O}), 33'hC);

        // Mask change in READY
        CH_EN_I = 16'h0006;
        cyc();
        chk("mk_drop", 33'({STATE_O, CH_EN_O}), 33'h30002);
        run(3);
        chk("mk_wait", 33'(CH_EN_O), 33'h0002);
        cyc();
        chk("mk_done", 33'({READY_O, CH_EN_O}), 33'h10006);

        // Fault filter
        BG_VALID_I = 1'b0;
        run(2);
        chk("ff_two_low", 33'(STATE_O), 33'd4);
        BG_VALID_I = 1'b1;
        cyc();
        BG_VALID_I = 1'b0;
        run(2);
        chk("ff_filter_reset", 33'(STATE_O), 33'd4);
        cyc();
        chk("ff_fault", 33'({STATE_O, FAULT_O, EN_IBIAS_O, EN_VBIAS_O, READY_O}), 33'h58);
        chk("ff_ch_clear", 33'(CH_EN_O), 33'h0);
        BG_VALID_I = 1'b1; EN_I = 1'b0;
        cyc();
        chk("ff_off", 33'({STATE_O, FAULT_O}), 33'h0);

        // Async reset during RAMP
        CH_EN_I = 16'h000F; EN_I = 1'b1;
        run(162);
        chk("ar_in_ramp", 33'(STATE_O), 33'd3);
        RST_I = 1'b1;
        #1;
        chk("ar_outputs", dut_out(), 33'h0);
        model_reset();
        @(posedge CLK_I);
        #2;
        RST_I = 1'b0;

        // Settle failure
        cyc();                                   // edge k
        run(159);
        BG_VALID_I = 1'b0;
        cyc();                                   // k+160
        chk("sf_fault", 33'({STATE_O, FAULT_O, EN_IBIAS_O, EN_VBIAS_O}), 33'h2C);
        chk("sf_ch", 33'(CH_EN_O), 33'h0);
        EN_I = 1'b0; BG_VALID_I = 1'b1;
        cyc();
        chk("sf_off", 33'({STATE_O, FAULT_O}), 33'h0);

        // Random traffic against the model
        EN_I = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            if (EN_I) begin
                if ($urandom_range(0, 399) == 0) EN_I = 1'b0;
            end else if ($urandom_range(0, 2) == 0) EN_I = 1'b1;
            if (BG_VALID_I) begin
                if ($urandom_range(0, 149) == 0) BG_VALID_I = 1'b0;
            end else if ($urandom_range(0, 1) == 0) BG_VALID_I = 1'b1;
            TRIM_LOAD_I = ($urandom_range(0, 199) == 0);
            TRIM_IBIAS_I = 5'($urandom);
            TRIM_VBIAS_I = 4'($urandom);
            if ($urandom_range(0, 19) == 0) EN_VBIAS_I = ~EN_VBIAS_I;
            if ($urandom_range(0, 59) == 0)
                CH_EN_I = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            cyc();
        end

        chk("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibias_bg_seq.md
IBIAS_BG_SEQ -- requirements
Module: ibias_bg_seq

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- N_CH, 16: number of switchable current-source channels.
- TI_W, 5: IBIAS trim width.
- TV_W, 4: VBIAS trim width.
- STARTUP_CYC, 32: BG startup pulse length in cycles (>=1).
- SETTLE_CYC, 128: bandgap settle wait in cycles (>=1).
- RAMP_CYC, 4: cycles between successive channel enables (>=1).
- FILT_CYC, 3: consecutive low BG_VALID_I cycles that flag a fault (>=1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK_I, in, 1: clock.
- RST_I, in, 1: reset.
- EN_I, in, 1: bias request.
- EN_VBIAS_I, in, 1: VBIAS request.
- CH_EN_I, in, N_CH: requested channel mask.
- TRIM_IBIAS_I, in, TI_W: IBIAS trim value.
- TRIM_VBIAS_I, in, TV_W: VBIAS trim value.
- TRIM_LOAD_I, in, 1: trim latch strobe.
- BG_VALID_I, in, 1: bandgap-valid from the analog cell.
- EN_IBIAS_O, out, 1: enable to the analog cell.
- EN_VBIAS_O, out, 1: VBIAS enable.
- BG_STARTUP_O, out, 1: startup kick.
- TRIM_IBIAS_O, out, TI_W: latched IBIAS trim.
- TRIM_VBIAS_O, out, TV_W: latched VBIAS trim.
- CH_EN_O, out, N_CH: applied channel mask.
- READY_O, out, 1: bias usable.
- FAULT_O, out, 1: bandgap fault.
- STATE_O, out, 3: FSM state.

REQ-003 The block SHALL use one clock, CLK_I, with RST_I asynchronous and active-high; all state SHALL update on the rising edge of CLK_I.

Function
REQ-004 The FSM SHALL have six states with these encodings: OFF=0, STARTUP=1, SETTLE=2, RAMP=3, READY=4, FAULT=5. STATE_O SHALL equal the current state.

REQ-005 The evaluation priority per edge SHALL be: EN_I=0, then fault detection, then TRIM_LOAD_I, then ramp/settle progress.

REQ-006 EN_I=0 in any state SHALL force the next state to OFF. In OFF, all outputs SHALL be 0 except TRIM_*_O, which hold their values.

REQ-007 In OFF with EN_I=1, the block SHALL go to STARTUP, latch both trim inputs, and load the counter with STARTUP_CYC-1.

REQ-008 In STARTUP, BG_STARTUP_O=1 and EN_IBIAS_O=1. When the counter is 0, the block SHALL go to SETTLE and load the counter with SETTLE_CYC-1; otherwise it decrements the counter.

REQ-009 In SETTLE, BG_STARTUP_O=0 and EN_IBIAS_O=1. When the counter is 0:
- BG_VALID_I=1: go to RAMP and load the counter with RAMP_CYC-1.
- BG_VALID_I=0: go to FAULT.

REQ-010 In RAMP, the counter decrements each cycle. At each edge where the counter is 0, the block SHALL set in CH_EN_O the lowest-index bit of (CH_EN_I & ~CH_EN_O) and reload the counter with RAMP_CYC-1.

REQ-011 In RAMP, whenever (CH_EN_I & ~CH_EN_O) is 0 after that edge's update (including the case CH_EN_I=0), the block SHALL go to READY on that same edge.

REQ-012 In RAMP and READY, a bit that is 0 in CH_EN_I SHALL clear the corresponding bit of CH_EN_O on the next edge, with no ramp delay.

REQ-013 In READY, any bit of CH_EN_I not set in CH_EN_O SHALL return the block to RAMP with the counter loaded to RAMP_CYC-1. READY_O SHALL be 1 only in READY.

REQ-014 TRIM_LOAD_I=1 in STARTUP, SETTLE, RAMP or READY SHALL latch both trims on that edge. In RAMP or READY it SHALL also move the block to SETTLE with the counter loaded to SETTLE_CYC-1, while CH_EN_O holds its value. In OFF and FAULT the strobe SHALL be ignored.

REQ-015 In RAMP and READY, a filter counter SHALL count consecutive cycles with BG_VALID_I=0 and clear whenever BG_VALID_I=1. Reaching FILT_CYC SHALL move the block to FAULT.

REQ-016 In FAULT:
- EN_IBIAS_O=0, EN_VBIAS_O=0, CH_EN_O=0, READY_O=0, FAULT_O=1.
- The block SHALL exit only to OFF via EN_I=0, and FAULT_O SHALL clear on entry to OFF.

REQ-017 EN_VBIAS_O SHALL equal EN_VBIAS_I AND (state in STARTUP..READY), registered.

REQ-018 All outputs SHALL be registered. The counter width SHALL be $clog2 of the largest cycle parameter plus 1, and the counter SHALL never wrap.

Reset
REQ-019 While RST_I=1:
- The state SHALL be OFF.
- All counters, CH_EN_O, TRIM_IBIAS_O, TRIM_VBIAS_O, EN_*_O, BG_STARTUP_O, READY_O and FAULT_O SHALL be 0.
- STATE_O SHALL be 0.

REQ-020 Reset asserted in mid-sequence SHALL return the block to OFF immediately. Operation SHALL resume only after RST_I=0 and an edge sampling EN_I=1.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults; EN_I sampled high at edge k, BG_VALID_I=1, CH_EN_I=0x0003):
- Normal power-up: BG_STARTUP_O=1 for edges k..k+31; SETTLE from k+32; RAMP from k+160; CH_EN_O=0x0001 at k+164; CH_EN_O=0x0003 and READY_O=1 at k+168.
- Settle failure: BG_VALID_I=0 at the end of SETTLE -> FAULT at k+160, FAULT_O=1, all enables 0; then EN_I=0 -> OFF, FAULT_O=0.
- Fault filter: in READY, BG_VALID_I low for 2 cycles -> stays READY; low for 3 cycles -> FAULT on the 3rd edge.
- Trim reload: in READY, TRIM_LOAD_I pulse with TRIM_IBIAS_I=5'h1A -> TRIM_IBIAS_O=5'h1A, SETTLE for 128 cycles with CH_EN_O=0x0003 held, then READY again.
- Mask change in READY: CH_EN_I 0x0003 -> 0x0006 gives CH_EN_O=0x0002 on the next edge, RAMP, then 0x0006 after 4 cycles and READY.
- Async reset during RAMP -> all outputs 0 without a clock edge, STATE_O=0.
